// File: rtl/instr_fetch_unit.sv
// Fetch stage of the single-issue MIPS pipeline: owns the PC, drives the instruction
// memory address and fills the IF/ID register under stall, redirect, halt and misalignment control.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000,
    parameter logic [31:0] PC_INCR  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        halted,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic [31:0] ifid_instr_r;
    logic [31:0] ifid_instr_nxt_s;
    logic [31:0] ifid_pc4_r;
    logic [31:0] ifid_pc4_nxt_s;
    logic        ifid_valid_r;
    logic        ifid_valid_nxt_s;
    logic        halted_r;
    logic        halted_nxt_s;
    logic        misalign_r;
    logic        misalign_nxt_s;
    logic [31:0] pc_seq_s;

    // A fetch is only legal from a word boundary.
    function automatic logic pc_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

    // Sequential successor; wraps modulo 2^32 by construction.
    function automatic logic [31:0] pc_next_seq(input logic [31:0] pc);
        return pc + PC_INCR;
    endfunction

    assign pc_seq_s = pc_next_seq(pc_r);

    // Next-state and next-register computation, priority halt > redirect > misalign > stall > fetch.
    always_comb begin
        state_nxt_s      = state_r;
        pc_nxt_s         = pc_r;
        ifid_instr_nxt_s = ifid_instr_r;
        ifid_pc4_nxt_s   = ifid_pc4_r;
        ifid_valid_nxt_s = ifid_valid_r;
        halted_nxt_s     = halted_r;
        misalign_nxt_s   = misalign_r;
        case (state_r)
            BOOT: begin
                state_nxt_s = RUN;
            end
            RUN: begin
                if (halt_req) begin
                    state_nxt_s      = HALT;
                    halted_nxt_s     = 1'b1;
                    ifid_instr_nxt_s = NOP_WORD;
                    ifid_pc4_nxt_s   = 32'h0000_0000;
                    ifid_valid_nxt_s = 1'b0;
                end else if (redirect_en) begin
                    pc_nxt_s         = redirect_target;
                    ifid_instr_nxt_s = NOP_WORD;
                    ifid_pc4_nxt_s   = 32'h0000_0000;
                    ifid_valid_nxt_s = 1'b0;
                end else if (pc_misaligned(pc_r)) begin
                    // The word at a misaligned address is never captured.
                    state_nxt_s      = HALT;
                    halted_nxt_s     = 1'b1;
                    misalign_nxt_s   = 1'b1;
                    ifid_instr_nxt_s = NOP_WORD;
                    ifid_pc4_nxt_s   = 32'h0000_0000;
                    ifid_valid_nxt_s = 1'b0;
                end else if (stall) begin
                    pc_nxt_s         = pc_r;
                    ifid_instr_nxt_s = ifid_instr_r;
                    ifid_pc4_nxt_s   = ifid_pc4_r;
                    ifid_valid_nxt_s = ifid_valid_r;
                end else begin
                    pc_nxt_s         = pc_seq_s;
                    ifid_instr_nxt_s = imem_rdata;
                    ifid_pc4_nxt_s   = pc_seq_s;
                    ifid_valid_nxt_s = 1'b1;
                end
            end
            HALT: begin
                state_nxt_s = HALT;
            end
            default: begin
                // Unreachable encoding: recover through BOOT with a flushed IF/ID.
                state_nxt_s      = BOOT;
                pc_nxt_s         = RESET_PC;
                ifid_instr_nxt_s = NOP_WORD;
                ifid_pc4_nxt_s   = 32'h0000_0000;
                ifid_valid_nxt_s = 1'b0;
                halted_nxt_s     = 1'b0;
            end
        endcase
    end

    // State, PC and IF/ID registers with synchronous reset overriding every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= BOOT;
            pc_r         <= RESET_PC;
            ifid_instr_r <= NOP_WORD;
            ifid_pc4_r   <= 32'h0000_0000;
            ifid_valid_r <= 1'b0;
            halted_r     <= 1'b0;
            misalign_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            ifid_instr_r <= ifid_instr_nxt_s;
            ifid_pc4_r   <= ifid_pc4_nxt_s;
            ifid_valid_r <= ifid_valid_nxt_s;
            halted_r     <= halted_nxt_s;
            misalign_r   <= misalign_nxt_s;
        end
    end

    assign imem_addr    = pc_r;
    assign ifid_instr   = ifid_instr_r;
    assign ifid_pc4     = ifid_pc4_r;
    assign ifid_valid   = ifid_valid_r;
    assign halted       = halted_r;
    assign misalign_err = misalign_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: the driver queues the expected post-edge state,
// a monitor on the falling edge pops and compares it; memory returns its own address.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_en;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        halted;
    logic        misalign_err;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        hlt;
        logic        mis;
        int          step;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_no  = 0;

    instr_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_en     (redirect_en),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .ifid_instr      (ifid_instr),
        .ifid_pc4        (ifid_pc4),
        .ifid_valid      (ifid_valid),
        .halted          (halted),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    // Memory model: the word stored at address A is A.
    assign imem_rdata = imem_addr;

    task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%08h, expected 0x%08h", name, step, act, req);
        end
    endtask

    // Drive one cycle of inputs and queue the state expected right after the edge.
    task automatic cyc(input logic r, input logic s, input logic re, input logic [31:0] tgt,
                       input logic h, input logic [31:0] epc, input logic [31:0] ei,
                       input logic [31:0] ep4, input logic ev, input logic eh, input logic em);
        exp_t e;
        rst = r; stall = s; redirect_en = re; redirect_target = tgt; halt_req = h;
        @(posedge clk);
        e.pc = epc; e.instr = ei; e.pc4 = ep4; e.valid = ev; e.hlt = eh; e.mis = em;
        e.step = step_no;
        step_no++;
        q.push_back(e);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("imem_addr",    e.step, imem_addr,            e.pc);
                chk("ifid_instr",   e.step, ifid_instr,           e.instr);
                chk("ifid_pc4",     e.step, ifid_pc4,             e.pc4);
                chk("ifid_valid",   e.step, {31'd0, ifid_valid},  {31'd0, e.valid});
                chk("halted",       e.step, {31'd0, halted},      {31'd0, e.hlt});
                chk("misalign_err", e.step, {31'd0, misalign_err},{31'd0, e.mis});
            end
        end
    end

    initial begin : driver
        rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_target = 32'h0; halt_req = 1'b0;
        // Reset two cycles, with noise on other inputs during the second.
        cyc(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,  32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0080, 1'b1, 32'h0,  32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        // BOOT then sequential fetch.
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h4, 32'h0, 32'h4, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h8, 32'h4, 32'h8, 1'b1, 1'b0, 1'b0);
        // Stall two cycles at pc=8, then release.
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h8, 32'h4, 32'h8, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h8, 32'h4, 32'h8, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hC, 32'h8, 32'hC, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h10, 32'hC, 32'h10, 1'b1, 1'b0, 1'b0);
        // Redirect with simultaneous stall at pc=0x10.
        cyc(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h44, 32'h40, 32'h44, 1'b1, 1'b0, 1'b0);
        // Wrap-around from the top word.
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h4, 32'h0, 32'h4, 1'b1, 1'b0, 1'b0);
        // Misaligned redirect: accepted, then error and halt.
        cyc(1'b0, 1'b0, 1'b1, 32'h12, 1'b0, 32'h12, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h12, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h12, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h12, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h12, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        // Reset clears the sticky error; redirect during BOOT is ignored.
        cyc(1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h4, 32'h0, 32'h4, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h8, 32'h4, 32'h8, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'hC, 32'h8, 32'hC, 1'b1, 1'b0, 1'b0);
        // Halt at pc=0xC (wins over redirect), then frozen for three cycles.
        cyc(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'hC, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'hC, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'hC, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'hC, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        // Reset (with stall asserted) exits HALT through BOOT into RUN.
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h4, 32'h0, 32'h4, 1'b1, 1'b0, 1'b0);
        // Reset in the middle of a redirect.
        cyc(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", step_no, q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
